// File: rtl/booth_mul_seq.sv
// booth_mul_seq
// Sequential radix-2 Booth multiplier controller. Produces the signed
// WIDTH x WIDTH -> 2*WIDTH product by stepping through the multiplier one
// bit per iteration. It owns no adder: add/subtract steps are issued to a
// shared 2*WIDTH adder through a request/grant port. Iterations whose Booth
// pair is 00 or 11 skip the adder entirely.
//
// Ports:
//   in_clk, in_rst_n          clock, asynchronous active-low reset
//   in_start                  one-cycle start pulse (honoured in IDLE/DONE)
//   in_multiplicand (M)       signed operand, sampled with in_start
//   in_multiplier   (Q)       signed operand, sampled with in_start
//   out_busy                  high while iterating (RUN)
//   out_done                  one-cycle pulse, out_result valid
//   out_result                signed 2*WIDTH product, held until replaced
//   out_add_req / in_add_gnt  shared-adder request / grant
//   out_add_x/_y/_cin         adder operands (all zero when not requesting)
//   in_add_sum                adder result, combinational from the operands
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_start,
  input  logic [WIDTH-1:0]     in_multiplicand,
  input  logic [WIDTH-1:0]     in_multiplier,
  output logic                 out_busy,
  output logic                 out_done,
  output logic [2*WIDTH-1:0]   out_result,
  output logic                 out_add_req,
  input  logic                 in_add_gnt,
  output logic [2*WIDTH-1:0]   out_add_x,
  output logic [2*WIDTH-1:0]   out_add_y,
  output logic                 out_add_cin,
  input  logic [2*WIDTH-1:0]   in_add_sum
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);
  localparam logic [IW-1:0] ONE_ITER  = IW'(1);

  logic [1:0]       state_r;
  logic [IW-1:0]    iter_r;
  logic [PW-1:0]    m_r;       // multiplicand, sign-extended to PW
  logic [WIDTH-1:0] q_r;
  logic             prev_r;    // q(i-1), the bit examined last iteration
  logic [PW-1:0]    p_r;       // running partial product
  logic [PW-1:0]    result_r;
  logic             done_r;

  logic [1:0]       pair_s;
  logic             req_s;
  logic             sub_s;
  logic [PW-1:0]    m_shift_s;
  logic             advance_s;
  logic [PW-1:0]    p_next_s;

  // Booth pair decode and shared-adder operand generation
  always_comb begin
    pair_s    = {q_r[iter_r], prev_r};
    m_shift_s = m_r << iter_r;
    req_s     = 1'b0;
    sub_s     = 1'b0;
    if (state_r == ST_RUN) begin
      case (pair_s)
        2'b01: begin
          req_s = 1'b1;
          sub_s = 1'b0;
        end
        2'b10: begin
          req_s = 1'b1;
          sub_s = 1'b1;
        end
        default: begin
          req_s = 1'b0;
          sub_s = 1'b0;
        end
      endcase
    end else begin
      req_s = 1'b0;
      sub_s = 1'b0;
    end

    // Subtraction is P + ~(M<<i) + 1; operands are forced to zero when idle
    // so the shared adder sees no stray activity from this requester.
    if (req_s) begin
      out_add_x   = p_r;
      out_add_y   = sub_s ? ~m_shift_s : m_shift_s;
      out_add_cin = sub_s;
    end else begin
      out_add_x   = {PW{1'b0}};
      out_add_y   = {PW{1'b0}};
      out_add_cin = 1'b0;
    end

    // A non-requesting iteration always completes; a requesting one waits
    // for the grant. The grant never feeds back into the request itself.
    if (req_s) begin
      advance_s = in_add_gnt;
      p_next_s  = in_add_sum;
    end else begin
      advance_s = 1'b1;
      p_next_s  = p_r;
    end
  end

  // Controller state, operand latches, partial product and result
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_r  <= ST_IDLE;
      iter_r   <= {IW{1'b0}};
      m_r      <= {PW{1'b0}};
      q_r      <= {WIDTH{1'b0}};
      prev_r   <= 1'b0;
      p_r      <= {PW{1'b0}};
      result_r <= {PW{1'b0}};
      done_r   <= 1'b0;
    end else begin
      // done is registered from the DONE state so it coincides with the
      // first cycle in which out_result carries the new product stably.
      done_r <= (state_r == ST_DONE);
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (in_start) begin
            m_r     <= {{WIDTH{in_multiplicand[WIDTH-1]}}, in_multiplicand};
            q_r     <= in_multiplier;
            p_r     <= {PW{1'b0}};
            iter_r  <= {IW{1'b0}};
            prev_r  <= 1'b0;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (advance_s) begin
            p_r    <= p_next_s;
            prev_r <= q_r[iter_r];
            if (iter_r == LAST_ITER) begin
              result_r <= p_next_s;
              state_r  <= ST_DONE;
            end else begin
              iter_r <= iter_r + ONE_ITER;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_busy    = (state_r == ST_RUN);
  assign out_done    = done_r;
  assign out_result  = result_r;
  assign out_add_req = req_s;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Testbench for booth_mul_seq: randomized and directed operands, a
// behavioural adder, and a reference model built from signed arithmetic
// and the Booth pair rule.
module tb_booth_mul_seq;

  localparam int W = 32;

  logic          in_clk;
  logic          in_rst_n;
  logic          in_start;
  logic [W-1:0]  in_multiplicand;
  logic [W-1:0]  in_multiplier;
  logic          out_busy;
  logic          out_done;
  logic [2*W-1:0] out_result;
  logic          out_add_req;
  logic          in_add_gnt;
  logic [2*W-1:0] out_add_x;
  logic [2*W-1:0] out_add_y;
  logic          out_add_cin;
  logic [2*W-1:0] in_add_sum;

  int n_checks;
  int n_fail;

  booth_mul_seq #(.WIDTH(W)) dut (
    .in_clk          (in_clk),
    .in_rst_n        (in_rst_n),
    .in_start        (in_start),
    .in_multiplicand (in_multiplicand),
    .in_multiplier   (in_multiplier),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_result      (out_result),
    .out_add_req     (out_add_req),
    .in_add_gnt      (in_add_gnt),
    .out_add_x       (out_add_x),
    .out_add_y       (out_add_y),
    .out_add_cin     (out_add_cin),
    .in_add_sum      (in_add_sum)
  );

  // Shared adder stand-in
  assign in_add_sum = out_add_x + out_add_y + 64'(out_add_cin);

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    longint a;
    longint b;
    a = longint'($signed(m));
    b = longint'($signed(q));
    return 64'(a * b);
  endfunction

  // Drives one multiply (or continues one already started) and observes it
  // cycle by cycle until out_done. Counts anomalies for the caller to judge.
  task automatic run_op(
    input  logic [31:0] m, input logic [31:0] q, input bit skip_start,
    input  int gnt_mode, input int stall_target,
    input  int inj_cyc, input logic [31:0] inj_m, input logic [31:0] inj_q,
    input  bit chain, input logic [31:0] chain_m, input logic [31:0] chain_q,
    output logic [63:0] res, output int lat, output int denied,
    output logic [31:0] reqmask, output logic [31:0] submask,
    output int bad_ops, output int bad_busy, output int unstable,
    output bit timed_out);
    logic [63:0] m64, p_model, shifted, exp_y, px, py;
    logic pc, pb, exp_req, stalled;
    int cyc, remaining, reqs_done, exp_reqs, iter;
    bit deny;
    res = 64'd0; lat = 0; denied = 0; reqmask = 32'd0; submask = 32'd0;
    bad_ops = 0; bad_busy = 0; unstable = 0; timed_out = 1'b0;
    m64 = {{32{m[31]}}, m};
    p_model = 64'd0; px = 64'd0; py = 64'd0; pc = 1'b0; stalled = 1'b0;
    remaining = stall_target; reqs_done = 0; exp_reqs = 0;
    for (int i = 0; i < W; i++) begin
      pb = (i == 0) ? 1'b0 : q[(i == 0) ? 0 : i - 1];
      if (q[i] != pb) exp_reqs++;
    end
    if (!skip_start) begin
      @(negedge in_clk);
      in_start = 1'b1; in_multiplicand = m; in_multiplier = q;
      @(posedge in_clk);
      @(negedge in_clk);
    end
    cyc = 0;
    forever begin
      in_start = 1'b0;
      if (out_done && cyc > 0) begin
        lat = cyc;
        break;
      end
      if (cyc > 400) begin
        timed_out = 1'b1;
        break;
      end
      iter = cyc - denied;
      if (out_busy !== (iter < W)) bad_busy++;
      if (iter < W) begin
        pb = (iter == 0) ? 1'b0 : q[(iter == 0) ? 0 : iter - 1];
        exp_req = (q[iter] != pb);
      end else begin
        exp_req = 1'b0;
      end
      if (out_add_req !== exp_req) bad_ops++;
      if (out_add_req) begin
        if (iter < W) begin
          reqmask[iter] = 1'b1;
          submask[iter] = out_add_cin;
          shifted = m64 << iter;
          exp_y = q[iter] ? ~shifted : shifted;
          if (out_add_y !== exp_y || out_add_x !== p_model || out_add_cin !== q[iter]) bad_ops++;
        end
        if (stalled && (out_add_x !== px || out_add_y !== py || out_add_cin !== pc)) unstable++;
        case (gnt_mode)
          1: deny = ($urandom_range(0, 3) == 0);
          2: deny = (remaining > 0) && ((reqs_done == exp_reqs - 1) || ($urandom_range(0, 1) == 1));
          default: deny = 1'b0;
        endcase
        in_add_gnt = !deny;
        if (deny) begin
          denied++; remaining--; stalled = 1'b1;
          px = out_add_x; py = out_add_y; pc = out_add_cin;
        end else begin
          p_model = p_model + out_add_y + 64'(out_add_cin);
          reqs_done++; stalled = 1'b0;
        end
      end else begin
        if (out_add_x !== 64'd0 || out_add_y !== 64'd0 || out_add_cin !== 1'b0) bad_ops++;
        if (stalled) unstable++;
        stalled = 1'b0;
        in_add_gnt = 1'($urandom_range(0, 1));
      end
      if (cyc == inj_cyc) begin
        in_start = 1'b1; in_multiplicand = inj_m; in_multiplier = inj_q;
      end
      if (chain && cyc > 0 && iter == W) begin
        in_start = 1'b1; in_multiplicand = chain_m; in_multiplier = chain_q;
      end
      @(posedge in_clk);
      cyc++;
      @(negedge in_clk);
    end
    in_add_gnt = 1'b1;
    res = out_result;
  endtask

  task automatic test_reset();
    in_rst_n = 1'b0;
    #12;
    n_checks++;
    if (out_busy !== 1'b0 || out_done !== 1'b0 || out_add_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b req=%b expected 0 0 0", out_busy, out_done, out_add_req);
    end
    n_checks++;
    if (out_result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h expected 0", out_result);
    end
    n_checks++;
    if (out_add_x !== 64'd0 || out_add_y !== 64'd0 || out_add_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_operands: x=%h y=%h cin=%b expected zeros", out_add_x, out_add_y, out_add_cin);
    end
    @(negedge in_clk);
    in_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [63:0] res; logic [31:0] rm, sm;
    int lat, dn, bo, bb, us; bit to;
    run_op(32'd3, 32'd5, 1'b0, 0, 0, -1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0,
           res, lat, dn, rm, sm, bo, bb, us, to);
    n_checks++;
    if (to || res !== 64'd15) begin
      n_fail++; $display("FAIL basic_result: got %h (timeout %0d) expected 15", res, to);
    end
    n_checks++;
    if (lat !== 33) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected 33", lat);
    end
    n_checks++;
    if (rm !== 32'h0000_000F || sm !== 32'h0000_0005) begin
      n_fail++; $display("FAIL basic_requests: reqmask %h submask %h expected f 5", rm, sm);
    end
    n_checks++;
    if (bo !== 0 || bb !== 0) begin
      n_fail++; $display("FAIL basic_ports: bad_ops %0d bad_busy %0d expected 0 0", bo, bb);
    end
    @(negedge in_clk);
    n_checks++;
    if (out_done !== 1'b0 || out_result !== 64'd15) begin
      n_fail++; $display("FAIL basic_done_pulse: done %b result %h expected 0 15", out_done, out_result);
    end
  endtask

  task automatic test_corners();
    logic [31:0] ms [4];
    logic [31:0] qs [4];
    logic [63:0] res, exp; logic [31:0] rm, sm;
    int lat, dn, bo, bb, us; bit to;
    ms[0] = 32'hFFFF_FFF9; qs[0] = 32'd6;
    ms[1] = 32'h8000_0000; qs[1] = 32'h8000_0000;
    ms[2] = 32'hFFFF_FFFF; qs[2] = 32'hFFFF_FFFF;
    ms[3] = 32'h0000_1234; qs[3] = 32'd0;
    for (int k = 0; k < 4; k++) begin
      run_op(ms[k], qs[k], 1'b0, 0, 0, -1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0,
             res, lat, dn, rm, sm, bo, bb, us, to);
      case (k)
        0: exp = 64'hFFFF_FFFF_FFFF_FFD6;
        1: exp = 64'h4000_0000_0000_0000;
        2: exp = 64'd1;
        default: exp = 64'd0;
      endcase
      n_checks++;
      if (to || res !== exp || lat !== 33) begin
        n_fail++; $display("FAIL corner_%0d: got %h lat %0d expected %h lat 33", k, res, lat, exp);
      end
      n_checks++;
      if (bo !== 0 || bb !== 0) begin
        n_fail++; $display("FAIL corner_%0d_ports: bad_ops %0d bad_busy %0d expected 0 0", k, bo, bb);
      end
    end
    n_checks++;
    if (rm !== 32'd0) begin
      n_fail++; $display("FAIL corner_q0_noreq: reqmask %h expected 0", rm);
    end
  endtask

  task automatic test_stalls();
    logic [63:0] res; logic [31:0] rm, sm;
    int lat, dn, bo, bb, us; bit to;
    run_op(32'd3, 32'd5, 1'b0, 2, 10, -1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0,
           res, lat, dn, rm, sm, bo, bb, us, to);
    n_checks++;
    if (to || res !== 64'd15 || dn !== 10) begin
      n_fail++; $display("FAIL stall_result: got %h denied %0d expected 15 denied 10", res, dn);
    end
    n_checks++;
    if (lat !== 43) begin
      n_fail++; $display("FAIL stall_latency: got %0d expected 43", lat);
    end
    n_checks++;
    if (us !== 0 || bo !== 0 || bb !== 0) begin
      n_fail++; $display("FAIL stall_stable: unstable %0d bad_ops %0d bad_busy %0d expected 0", us, bo, bb);
    end
    // Only request is at the last iteration; hold it off for 60 cycles
    run_op(32'd7, 32'h8000_0000, 1'b0, 2, 60, -1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0,
           res, lat, dn, rm, sm, bo, bb, us, to);
    n_checks++;
    if (to || res !== ref_mul(32'd7, 32'h8000_0000) || lat !== 93 || us !== 0 || bo !== 0) begin
      n_fail++; $display("FAIL stall_last_iter: got %h lat %0d unstable %0d bad_ops %0d expected %h lat 93", res, lat, us, bo, ref_mul(32'd7, 32'h8000_0000));
    end
  endtask

  task automatic test_random();
    logic [63:0] res, exp; logic [31:0] rm, sm, m, q;
    int lat, dn, bo, bb, us; bit to;
    for (int k = 0; k < 20; k++) begin
      m = $urandom; q = $urandom;
      run_op(m, q, 1'b0, 1, 0, -1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0,
             res, lat, dn, rm, sm, bo, bb, us, to);
      exp = ref_mul(m, q);
      n_checks++;
      if (to || res !== exp || lat !== 33 + dn) begin
        n_fail++; $display("FAIL random_%0d: m %h q %h got %h lat %0d expected %h lat %0d", k, m, q, res, lat, exp, 33 + dn);
      end
      n_checks++;
      if (us !== 0 || bo !== 0 || bb !== 0) begin
        n_fail++; $display("FAIL random_%0d_ports: unstable %0d bad_ops %0d bad_busy %0d expected 0", k, us, bo, bb);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; logic [31:0] rm, sm;
    int lat, dn, bo, bb, us; bit to;
    run_op(32'd3, 32'd5, 1'b0, 0, 0, 5, 32'h0000_0011, 32'h0000_0022, 1'b1, 32'hFFFF_FFF9, 32'd6,
           res, lat, dn, rm, sm, bo, bb, us, to);
    n_checks++;
    if (to || res !== 64'd15 || lat !== 33 || bo !== 0) begin
      n_fail++; $display("FAIL busy_start_ignored: got %h lat %0d bad_ops %0d expected 15 lat 33", res, lat, bo);
    end
    n_checks++;
    if (out_busy !== 1'b1) begin
      n_fail++; $display("FAIL done_start_no_idle: busy %b expected 1", out_busy);
    end
    run_op(32'hFFFF_FFF9, 32'd6, 1'b1, 0, 0, -1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0,
           res, lat, dn, rm, sm, bo, bb, us, to);
    n_checks++;
    if (to || res !== 64'hFFFF_FFFF_FFFF_FFD6 || lat !== 33 || bo !== 0 || bb !== 0) begin
      n_fail++; $display("FAIL chained_result: got %h lat %0d bad_ops %0d expected ffffffffffffffd6 lat 33", res, lat, bo);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res; logic [31:0] rm, sm;
    int lat, dn, bo, bb, us, seen; bit to;
    @(negedge in_clk);
    in_start = 1'b1; in_multiplicand = 32'd5; in_multiplier = 32'h0000_1000;
    @(posedge in_clk);
    @(negedge in_clk);
    in_start = 1'b0;
    repeat (12) begin
      @(posedge in_clk);
      @(negedge in_clk);
    end
    n_checks++;
    if (out_busy !== 1'b1 || out_add_req !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_pre: busy %b req %b expected 1 1", out_busy, out_add_req);
    end
    in_rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_busy !== 1'b0 || out_add_req !== 1'b0 || out_done !== 1'b0 || out_result !== 64'd0) begin
      n_fail++; $display("FAIL reset_mid_drop: busy %b req %b done %b result %h expected 0", out_busy, out_add_req, out_done, out_result);
    end
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge in_clk);
      if (out_done || out_busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_mid_no_done: activity cycles %0d expected 0", seen);
    end
    run_op(32'd2, 32'hFFFF_FFFD, 1'b0, 0, 0, -1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0,
           res, lat, dn, rm, sm, bo, bb, us, to);
    n_checks++;
    if (to || res !== 64'hFFFF_FFFF_FFFF_FFFA || lat !== 33) begin
      n_fail++; $display("FAIL reset_mid_after: got %h lat %0d expected fffffffffffffffa lat 33", res, lat);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    in_rst_n = 1'b0;
    in_start = 1'b0;
    in_multiplicand = 32'd0;
    in_multiplier = 32'd0;
    in_add_gnt = 1'b1;
    test_reset();
    test_basic();
    test_corners();
    test_stalls();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
